eth_tx_sched: RTL and testbench

Transmit scheduler that shares the single `eth_tx` MAC transmit path between `N` application requesters. It arbitrates packet requests round-robin, runs the `app_early_v`/`app_ready_v` header handshake on behalf of the winner, and muxes the winner's payload beats through to `eth_tx`. It generates `app_last_block_next`/`app_last_block_next_len` from the declared packet length, so requesters never track 64b/66b block alignment, and it flags length mismatches.

---
 rtl/eth_tx_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/eth_tx_sched.sv | 173 +++++++++++++++++
 tb/tb_eth_tx_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
// Shared constants and helpers for the eth_tx transmit scheduler.
// Holds the FSM state encoding, the default PCS block size and the round-robin index step.
package eth_tx_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  localparam int BLOCK_N_DEFAULT = 8;

  // Next requester index after idx, wrapping at n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Returns a one-hot grant for the first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin : pick
    int idx;
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    idx = 0;
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares the eth_tx application port between N requesters: round-robin packet arbitration,
// header handshake on behalf of the winner, payload mux and last-block hints from pkt_len.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int N           = 2,
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LEN_W       = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W   = 16,
  parameter int UDP_CS_W    = 16,
  parameter int BLOCK_N     = BLOCK_N_DEFAULT,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1)
) (
  input  logic                   clk,
  input  logic                   nreset,

  input  logic [N-1:0]           req_early_v_i,
  input  logic [N*PKT_LEN_W-1:0] req_pkt_len_i,
  input  logic [N*UDP_CS_W-1:0]  req_cs_i,
  input  logic [N*DATA_W-1:0]    req_data_i,
  input  logic [N*LEN_W-1:0]     req_len_i,
  input  logic [N-1:0]           req_last_i,
  input  logic [N-1:0]           req_cancel_i,
  output logic [N-1:0]           req_grant_o,

  output logic                   tx_early_v_o,
  input  logic                   tx_ready_v_i,
  output logic                   tx_cancel_o,
  output logic [DATA_W-1:0]      tx_data_o,
  output logic [LEN_W-1:0]       tx_len_o,
  output logic [PKT_LEN_W-1:0]   tx_pkt_len_o,
  output logic [UDP_CS_W-1:0]    tx_cs_o,
  output logic                   tx_last_o,
  output logic                   tx_last_block_next_o,
  output logic [BLOCK_LEN_W-1:0] tx_last_block_next_len_o,
  output logic                   len_err_o
);

  localparam int IDX_W = $clog2(N);
  localparam logic [PKT_LEN_W-1:0] BLK = PKT_LEN_W'(BLOCK_N);

  state_t                 state;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       rr_ptr;
  logic [PKT_LEN_W-1:0]   pkt_len;
  logic [PKT_LEN_W-1:0]   byte_cnt;

  logic [N-1:0]           arb_gnt;
  logic [IDX_W-1:0]       arb_idx;

  logic [PKT_LEN_W-1:0]   pkt_len_a [N];
  logic [UDP_CS_W-1:0]    cs_a      [N];
  logic [DATA_W-1:0]      data_a    [N];
  logic [LEN_W-1:0]       len_a     [N];

  logic                   w_early;
  logic                   w_cancel;
  logic                   w_last;
  logic [LEN_W-1:0]       w_len;
  logic [PKT_LEN_W-1:0]   byte_sum;
  logic                   req_abort;
  logic                   pkt_end;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pkt_len_a[i] = req_pkt_len_i[i*PKT_LEN_W +: PKT_LEN_W];
      cs_a[i]      = req_cs_i[i*UDP_CS_W +: UDP_CS_W];
      data_a[i]    = req_data_i[i*DATA_W +: DATA_W];
      len_a[i]     = req_len_i[i*LEN_W +: LEN_W];
    end
  end

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req (req_early_v_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) arb_idx = IDX_W'(i);
    end
  end

  assign w_early   = req_early_v_i[win];
  assign w_cancel  = req_cancel_i[win];
  assign w_last    = req_last_i[win];
  assign w_len     = len_a[win];
  assign byte_sum  = byte_cnt + PKT_LEN_W'(w_len);
  // Withdrawing the request counts as a cancel while the header is still pending.
  assign req_abort = !w_early || w_cancel;
  assign pkt_end   = w_cancel || w_last;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      win      <= '0;
      rr_ptr   <= '0;
      pkt_len  <= '0;
      byte_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (|req_early_v_i) begin
            win     <= arb_idx;
            pkt_len <= pkt_len_a[arb_idx];
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_abort) begin
            state <= ST_IDLE;
          end else if (tx_ready_v_i) begin
            byte_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          byte_cnt <= byte_sum;
          if (pkt_end) begin
            rr_ptr <= IDX_W'(next_idx(int'(win), N));
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state, so an asynchronous reset forces them all to 0 at once.
  always_comb begin
    req_grant_o              = '0;
    tx_early_v_o             = 1'b0;
    tx_cancel_o              = 1'b0;
    tx_data_o                = '0;
    tx_len_o                 = '0;
    tx_pkt_len_o             = '0;
    tx_cs_o                  = '0;
    tx_last_o                = 1'b0;
    tx_last_block_next_o     = 1'b0;
    tx_last_block_next_len_o = '0;
    len_err_o                = 1'b0;
    case (state)
      ST_REQ: begin
        tx_early_v_o = 1'b1;
        tx_pkt_len_o = pkt_len;
        tx_cs_o      = cs_a[win];
        if (req_abort) begin
          tx_cancel_o = 1'b1;
        end else if (tx_ready_v_i) begin
          req_grant_o[win] = 1'b1;
        end
      end
      ST_DATA: begin
        tx_data_o   = data_a[win];
        tx_len_o    = w_len;
        tx_last_o   = w_last;
        tx_cancel_o = w_cancel;
        // Hint goes out on the beat that starts the final, partially filled PCS block.
        if (!w_last && ((byte_cnt % BLK) == '0) && ((byte_cnt / BLK) == (pkt_len / BLK))) begin
          tx_last_block_next_o     = 1'b1;
          tx_last_block_next_len_o = BLOCK_LEN_W'(pkt_len % BLK);
        end
        len_err_o = w_last && !w_cancel && (byte_sum != pkt_len);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with N=2, DATA_W=16, BLOCK_N=8.
// A per-cycle vector table covers one full packet; tasks cover arbitration, cancel, errors and reset.
module tb_eth_tx_sched;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  req_early;
  logic [31:0] req_pkt_len;
  logic [31:0] req_cs;
  logic [31:0] req_data;
  logic [3:0]  req_len;
  logic [1:0]  req_last;
  logic [1:0]  req_cancel;
  logic [1:0]  req_grant;
  logic        tx_early_v, tx_ready_v, tx_cancel, tx_last, tx_lbn, len_err;
  logic [15:0] tx_data, tx_pkt_len, tx_cs;
  logic [1:0]  tx_len;
  logic [3:0]  tx_lbn_len;

  int n_checks = 0;
  int n_pass   = 0;

  eth_tx_sched #(.N(2), .DATA_W(16), .PKT_LEN_W(16), .UDP_CS_W(16), .BLOCK_N(8)) dut (
    .clk                      (clk),
    .nreset                   (nreset),
    .req_early_v_i            (req_early),
    .req_pkt_len_i            (req_pkt_len),
    .req_cs_i                 (req_cs),
    .req_data_i               (req_data),
    .req_len_i                (req_len),
    .req_last_i               (req_last),
    .req_cancel_i             (req_cancel),
    .req_grant_o              (req_grant),
    .tx_early_v_o             (tx_early_v),
    .tx_ready_v_i             (tx_ready_v),
    .tx_cancel_o              (tx_cancel),
    .tx_data_o                (tx_data),
    .tx_len_o                 (tx_len),
    .tx_pkt_len_o             (tx_pkt_len),
    .tx_cs_o                  (tx_cs),
    .tx_last_o                (tx_last),
    .tx_last_block_next_o     (tx_lbn),
    .tx_last_block_next_len_o (tx_lbn_len),
    .len_err_o                (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        early;
    logic        ready;
    logic [15:0] data;
    logic [1:0]  len;
    logic        last;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [63:0] pack(logic e, logic [1:0] g, logic c, logic [15:0] d,
                                       logic [1:0] l, logic la, logic lb, logic [3:0] lbl,
                                       logic le, logic [15:0] pl, logic [15:0] cs);
    return {3'b0, e, g, c, d, l, la, lb, lbl, le, pl, cs};
  endfunction

  function automatic logic [63:0] outs();
    return pack(tx_early_v, req_grant, tx_cancel, tx_data, tx_len, tx_last, tx_lbn,
                tx_lbn_len, len_err, tx_pkt_len, tx_cs);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_beat(input int r, input logic [15:0] d, input logic [1:0] l,
                          input logic la, input logic ca);
    req_data[r*16 +: 16] = d;
    req_len[r*2 +: 2]    = l;
    req_last[r]          = la;
    req_cancel[r]        = ca;
  endtask

  task automatic clear_beats();
    req_data   = '0;
    req_len    = '0;
    req_last   = '0;
    req_cancel = '0;
    tx_ready_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset    = 1'b0;
    req_early = '0;
    clear_beats();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // Returns at negedge+1 of the first cycle that shows tx_early_v, or flags a timeout.
  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (!tx_early_v && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("%s early", tag), 64'(tx_early_v), 64'd1);
  endtask

  // Serve one packet of 2-byte beats from requester r; cancel_at < 0 means no cancel.
  task automatic serve(input int r, input int nbeats, input int cancel_at, input logic keep,
                       input string tag);
    int sum = 0;
    logic [15:0] d;
    wait_req(tag);
    check($sformatf("%s hdr", tag), {32'd0, tx_pkt_len, tx_cs},
          {32'd0, req_pkt_len[r*16 +: 16], req_cs[r*16 +: 16]});
    tx_ready_v = 1'b1;
    #1;
    check($sformatf("%s grant", tag), 64'(req_grant), 64'(1) << r);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      tx_ready_v   = 1'b0;
      req_early[r] = keep;
      d = 16'((r + 1) << 12) | 16'(k);
      set_beat(r, d, 2'd2, k == nbeats - 1, k == cancel_at);
      #1;
      check($sformatf("%s data%0d", tag, k), 64'(tx_data), 64'(d));
      if (k == cancel_at) begin
        check($sformatf("%s cancel", tag), {62'd0, tx_cancel, len_err}, 64'b10);
        break;
      end
      sum += 2;
      if (k == nbeats - 1)
        check($sformatf("%s len_err", tag), 64'(len_err),
              64'(sum != int'(req_pkt_len[r*16 +: 16])));
    end
    @(negedge clk);
    clear_beats();
    #1;
    check($sformatf("%s idle", tag), {62'd0, tx_early_v, tx_cancel}, 64'd0);
  endtask

  initial begin
    nreset      = 1'b0;
    req_early   = '0;
    req_pkt_len = {16'd4, 16'd21};
    req_cs      = {16'hCAFE, 16'hBEEF};
    clear_beats();

    tbl[0] = '{1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 64'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0, 2'd0, 1'b0, pack(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'd21, 16'hBEEF)};
    tbl[2] = tbl[1];
    tbl[3] = '{1'b1, 1'b1, 16'h0, 2'd0, 1'b0, pack(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 16'd21, 16'hBEEF)};
    for (int k = 0; k < 11; k++) begin
      logic [1:0] l;
      l = (k == 10) ? 2'd1 : 2'd2;
      tbl[4+k] = '{1'b0, 1'b0, 16'hA000 + 16'(k), l, k == 10,
                   pack(0, 2'b00, 0, 16'hA000 + 16'(k), l, k == 10, k == 8,
                        (k == 8) ? 4'd5 : 4'd0, 0, 16'd0, 16'd0)};
    end
    tbl[15] = '{1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 64'd0};

    repeat (2) @(negedge clk);
    req_early = 2'b01;
    #1;
    check("reset outputs", outs(), 64'd0);
    req_early = 2'b00;
    nreset    = 1'b1;

    // Single packet, pkt_len=21: ready after 3 REQ cycles, 11 beats, hint at offset 16.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_early[0] = tbl[i].early;
      tx_ready_v   = tbl[i].ready;
      set_beat(0, tbl[i].data, tbl[i].len, tbl[i].last, 1'b0);
      #1;
      check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
    end

    // Both requesting from reset: 0, 1, 0.
    do_reset();
    req_pkt_len = {16'd4, 16'd4};
    req_early   = 2'b11;
    serve(0, 2, -1, 1'b1, "rr0");
    serve(1, 2, -1, 1'b1, "rr1");
    serve(0, 2, -1, 1'b1, "rr2");

    // Requester 1 wins next and cancels on its 3rd beat; requester 0 follows.
    serve(1, 5, 2, 1'b0, "cancel1");
    serve(0, 2, -1, 1'b0, "after_cancel");

    // Cancel in REQ together with ready: no grant, tx_cancel pulse.
    req_early = 2'b01;
    wait_req("cxr");
    req_cancel[0] = 1'b1;
    tx_ready_v    = 1'b1;
    #1;
    check("cxr grant/cancel", {61'd0, req_grant, tx_cancel}, 64'b001);
    @(negedge clk);
    req_early = 2'b00;
    clear_beats();
    #1;
    check("cxr idle", {62'd0, tx_early_v, tx_cancel}, 64'd0);

    // Declared 20 bytes, 22 sent.
    req_pkt_len[15:0] = 16'd20;
    req_early = 2'b01;
    serve(0, 11, -1, 1'b0, "lenerr");
    req_pkt_len[15:0] = 16'd4;

    // Reset in the middle of a requester-1 packet, while rr_ptr points at 1.
    req_early = 2'b10;
    wait_req("rst");
    tx_ready_v = 1'b1;
    #1;
    check("rst grant", 64'(req_grant), 64'b10);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tx_ready_v = 1'b0;
      req_early  = 2'b00;
      set_beat(1, 16'h5A50 + 16'(k), 2'd2, 1'b0, 1'b0);
      #1;
      check($sformatf("rst data%0d", k), 64'(tx_data), 64'(16'h5A50 + 16'(k)));
    end
    #2;
    nreset = 1'b0;
    #1;
    check("rst async outputs", outs(), 64'd0);
    @(negedge clk);
    clear_beats();
    nreset    = 1'b1;
    req_early = 2'b11;
    serve(0, 2, -1, 1'b0, "post_rst");
    req_early = 2'b00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
